// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: MEM-stage loads/stores and instruction fetches share one byte-wide RAM port.
// Optional macro MEM_CTRL_IFETCH_BUF_EN adds a one-entry fetch buffer that answers repeat fetches without RAM traffic.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data_i,
    input  logic [2:0]            mem_length,
    input  logic                  mem_signed,
    output logic                  mem_busy,
    output logic                  mem_ready,
    output logic [31:0]           mem_data_o,
    input  logic                  if_read,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_busy,
    output logic                  if_ready,
    output logic [31:0]           if_data_o,
    output logic [ADDR_WIDTH-1:0] ram_a,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [2:0]            r_len;
    logic [2:0]            r_cnt;
    logic                  r_signed;
    logic                  r_owner_if;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [7:0]            r_ram_dout;
    logic                  r_ram_wr;
    logic                  r_mem_ready;
    logic                  r_if_ready;
    logic [31:0]           r_mem_data;
    logic [31:0]           r_if_data;
`ifdef MEM_CTRL_IFETCH_BUF_EN
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [31:0]           r_buf_data;
`endif

    logic                  w_mem_wr_req;
    logic                  w_mem_rd_req;
    logic                  w_if_req;
    logic [2:0]            w_req_len;
    logic [1:0]            w_lane;
    logic [31:0]           w_rdata;
    logic [31:0]           w_rdata_ext;
    logic [ADDR_WIDTH-1:0] w_next_a;
    logic [7:0]            w_wbyte;

    // A requester still seeing its own ready pulse is ignored, so a held level request is not re-served.
    assign w_mem_wr_req = mem_write & ~r_mem_ready;
    assign w_mem_rd_req = mem_read  & ~r_mem_ready;
    assign w_if_req     = if_read   & ~r_if_ready;
    assign w_req_len    = (mem_length == 3'd1) ? 3'd1 : (mem_length == 3'd2) ? 3'd2 : 3'd4;
    assign w_lane       = r_cnt[1:0] - 2'd1;
    assign w_next_a     = r_base + ADDR_WIDTH'(r_cnt);
    assign w_wbyte      = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        w_rdata = r_rdata;
        w_rdata[{w_lane, 3'b000} +: 8] = ram_din;
        case (r_len)
            3'd1:    w_rdata_ext = {{24{r_signed & w_rdata[7]}},  w_rdata[7:0]};
            3'd2:    w_rdata_ext = {{16{r_signed & w_rdata[15]}}, w_rdata[15:0]};
            default: w_rdata_ext = w_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= 3'd0;
            r_cnt       <= 3'd0;
            r_signed    <= 1'b0;
            r_owner_if  <= 1'b0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_ram_a     <= '0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_ready  <= 1'b0;
            r_mem_data  <= 32'd0;
            r_if_data   <= 32'd0;
`ifdef MEM_CTRL_IFETCH_BUF_EN
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= 32'd0;
`endif
        end else begin
            r_mem_ready <= 1'b0;
            r_if_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_wr_req) begin
                        r_base     <= mem_addr;
                        r_len      <= w_req_len;
                        r_owner_if <= 1'b0;
                        r_wdata    <= mem_data_i;
                        r_ram_a    <= mem_addr;
                        r_ram_dout <= mem_data_i[7:0];
                        r_ram_wr   <= 1'b1;
                        r_cnt      <= 3'd1;
                        r_state    <= S_WRITE;
`ifdef MEM_CTRL_IFETCH_BUF_EN
                        r_buf_valid <= 1'b0;
`endif
                    end else if (w_mem_rd_req) begin
                        r_base     <= mem_addr;
                        r_len      <= w_req_len;
                        r_signed   <= mem_signed;
                        r_owner_if <= 1'b0;
                        r_rdata    <= 32'd0;
                        r_ram_a    <= mem_addr;
                        r_cnt      <= 3'd1;
                        r_state    <= S_READ;
`ifdef MEM_CTRL_IFETCH_BUF_EN
                    end else if (w_if_req && r_buf_valid && (r_buf_addr == if_addr)) begin
                        r_if_ready <= 1'b1;
                        r_if_data  <= r_buf_data;
`endif
                    end else if (w_if_req) begin
                        r_base     <= if_addr;
                        r_len      <= 3'd4;
                        r_signed   <= 1'b0;
                        r_owner_if <= 1'b1;
                        r_rdata    <= 32'd0;
                        r_ram_a    <= if_addr;
                        r_cnt      <= 3'd1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_cnt == r_len) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 3'd0;
                        if (r_owner_if) begin
                            r_if_ready <= 1'b1;
                            r_if_data  <= w_rdata;
`ifdef MEM_CTRL_IFETCH_BUF_EN
                            r_buf_valid <= 1'b1;
                            r_buf_addr  <= r_base;
                            r_buf_data  <= w_rdata;
`endif
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_mem_data  <= w_rdata_ext;
                        end
                    end else begin
                        r_rdata <= w_rdata;
                        r_ram_a <= w_next_a;
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == r_len) begin
                        r_ram_wr    <= 1'b0;
                        r_state     <= S_IDLE;
                        r_cnt       <= 3'd0;
                        r_mem_ready <= 1'b1;
                    end else begin
                        r_ram_a    <= w_next_a;
                        r_ram_dout <= w_wbyte;
                        r_cnt      <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_busy   = (r_state != S_IDLE);
    assign if_busy    = mem_busy;
    assign mem_ready  = r_mem_ready;
    assign if_ready   = r_if_ready;
    assign mem_data_o = r_mem_data;
    assign if_data_o  = r_if_data;
    assign ram_a      = r_ram_a;
    assign ram_dout   = r_ram_dout;
    assign ram_wr     = r_ram_wr;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random loads/stores/fetches against a byte-array model.
// Fetch-buffer expectations follow MEM_CTRL_IFETCH_BUF_EN when it is defined.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_signed, if_read;
    logic [31:0] mem_addr, mem_data_i, if_addr;
    logic [2:0]  mem_length;
    logic        mem_busy, mem_ready, if_busy, if_ready, ram_wr;
    logic [31:0] mem_data_o, if_data_o, ram_a;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0]  ram [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [7:0]  bd_data;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_mem = 32'd0;
    logic [31:0] last_if = 32'd0;
    bit          buf_valid = 1'b0;
    logic [31:0] buf_addr = 32'd0;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_length(mem_length), .mem_signed(mem_signed),
        .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_data_o(mem_data_o),
        .if_read(if_read), .if_addr(if_addr), .if_busy(if_busy), .if_ready(if_ready),
        .if_data_o(if_data_o), .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM: data for the presented address is available at the following edge.
    assign ram_din = ram[ram_a[9:0]];
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] len);
        return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[10'(a + 32'(k))]) << (8 * k);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [2:0] len, input bit sgn);
        int n, lat;
        logic [31:0] exp;
        n = nbytes(len);
        exp = ref_load(a, n, sgn);
        mem_addr = a; mem_length = len; mem_signed = sgn; mem_read = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat = i + 1;
            if (mem_ready) break;
            chk("ld_busy", 32'(mem_busy), 32'd1);
            if (i < n) begin
                chk("ld_addr", ram_a, a + 32'(i));
                chk("ld_wr", 32'(ram_wr), 32'd0);
            end
        end
        mem_read = 1'b0;
        chk("ld_lat", 32'(lat), 32'(n + 1));
        chk("ld_data", mem_data_o, exp);
        chk("ld_busy_rdy", 32'(mem_busy), 32'd0);
        chk("ld_if_hold", if_data_o, last_if);
        last_mem = exp;
        tick;
        chk("ld_pulse", 32'(mem_ready), 32'd0);
        chk("ld_idle", 32'(mem_busy), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
        int n, lat;
        n = nbytes(len);
        mem_addr = a; mem_data_i = d; mem_length = len; mem_write = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat = i + 1;
            if (mem_ready) break;
            if (i < n) begin
                chk("st_wr", 32'(ram_wr), 32'd1);
                chk("st_addr", ram_a, a + 32'(i));
                chk("st_byte", 32'(ram_dout), (d >> (8 * i)) & 32'hFF);
            end
        end
        mem_write = 1'b0;
        chk("st_lat", 32'(lat), 32'(n + 1));
        chk("st_wr_end", 32'(ram_wr), 32'd0);
        chk("st_mem_hold", mem_data_o, last_mem);
        for (int k = 0; k < n; k++) ref_mem[10'(a + 32'(k))] = 8'(d >> (8 * k));
        buf_valid = 1'b0;
        tick;
        chk("st_pulse", 32'(mem_ready), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int lat, exp_lat;
        bit hit;
        logic [31:0] exp, a_before;
`ifdef MEM_CTRL_IFETCH_BUF_EN
        hit = buf_valid && (buf_addr == a);
`else
        hit = 1'b0;
`endif
        exp_lat = hit ? 1 : 5;
        exp = ref_load(a, 4, 1'b0);
        a_before = ram_a;
        if_addr = a; if_read = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat = i + 1;
            if (if_ready) break;
            chk("if_busy", 32'(if_busy), 32'd1);
            if (i < 4) chk("if_addr", ram_a, a + 32'(i));
        end
        if_read = 1'b0;
        chk("if_lat", 32'(lat), 32'(exp_lat));
        chk("if_data", if_data_o, exp);
        chk("if_mem_hold", mem_data_o, last_mem);
        if (hit) chk("if_noram", ram_a, a_before);
        last_if = exp;
        buf_valid = 1'b1;
        buf_addr = a;
        tick;
        chk("if_pulse", 32'(if_ready), 32'd0);
    endtask

    initial begin
        int lat, op;
        logic [31:0] ra, rd, prev_fetch;
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_signed = 1'b0; if_read = 1'b0;
        mem_addr = 32'd0; mem_data_i = 32'd0; if_addr = 32'd0; mem_length = 3'd4;
        bd_we = 1'b0; bd_addr = 10'd0; bd_data = 8'd0;
        prev_fetch = 32'd0;

        // Fill RAM and model with identical random bytes while reset is held.
        for (int i = 0; i < 1024; i++) begin
            bd_addr = 10'(i);
            bd_data = 8'($urandom);
            ref_mem[i] = bd_data;
            bd_we = 1'b1;
            tick;
        end
        bd_we = 1'b0;
        tick;

        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_ifbusy", 32'(if_busy), 32'd0);
        chk("rst_ready", {30'd0, mem_ready, if_ready}, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_dout_wr", {23'd0, ram_wr, ram_dout}, 32'd0);
        chk("rst_mdata", mem_data_o, 32'd0);
        chk("rst_idata", if_data_o, 32'd0);
        reset = 1'b0;
        tick;

        // Unsigned byte, signed halfword, word store and readback.
        do_store(32'h100, 32'h0000_0080, 3'd1);
        do_load(32'h100, 3'd1, 1'b0);
        do_load(32'h100, 3'd1, 1'b1);
        do_store(32'h200, 32'h0000_F234, 3'd2);
        do_load(32'h200, 3'd2, 1'b1);
        do_load(32'h200, 3'd2, 1'b0);
        do_store(32'h10, 32'hDEAD_BEEF, 3'd4);
        do_load(32'h10, 3'd4, 1'b1);

        // Simultaneous MEM load and fetch: MEM first, fetch accepted on the edge ending mem_ready.
        mem_addr = 32'h100; mem_length = 3'd1; mem_signed = 1'b0; mem_read = 1'b1;
        if_addr = 32'h40; if_read = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat = i + 1;
            if (mem_ready) break;
            chk("arb_ifbusy", 32'(if_busy), 32'd1);
            chk("arb_if_wait", 32'(if_ready), 32'd0);
        end
        mem_read = 1'b0;
        chk("arb_mlat", 32'(lat), 32'd2);
        chk("arb_mdata", mem_data_o, ref_load(32'h100, 1, 1'b0));
        last_mem = ref_load(32'h100, 1, 1'b0);
        tick;
        chk("arb_if_accept", 32'(if_busy), 32'd1);
        chk("arb_if_addr", ram_a, 32'h40);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat = lat + 1;
            if (if_ready) break;
        end
        if_read = 1'b0;
        chk("arb_iflat", 32'(lat), 32'd5);
        chk("arb_ifdata", if_data_o, ref_load(32'h40, 4, 1'b0));
        last_if = ref_load(32'h40, 4, 1'b0);
        buf_valid = 1'b1;
        buf_addr = 32'h40;
        tick;

        // Repeat fetch, then a store invalidates any buffered word.
        do_fetch(32'h0);
        do_fetch(32'h0);
        do_store(32'h3F0, 32'h1234_5678, 3'd4);
        do_fetch(32'h0);

        // Reset after two store bytes have been written.
        mem_addr = 32'h300; mem_data_i = 32'hA1B2_C3D4; mem_length = 3'd4; mem_write = 1'b1;
        tick;
        chk("rs_wr0", 32'(ram_wr), 32'd1);
        tick;
        tick;
        chk("rs_a2", ram_a, 32'h302);
        #1 reset = 1'b1;
        #1;
        chk("rs_wr_off", 32'(ram_wr), 32'd0);
        chk("rs_busy", 32'(mem_busy), 32'd0);
        chk("rs_ram_a", ram_a, 32'd0);
        mem_write = 1'b0;
        tick;
        chk("rs_noready", 32'(mem_ready), 32'd0);
        reset = 1'b0;
        ref_mem[10'h300] = 8'hD4;
        ref_mem[10'h301] = 8'hC3;
        buf_valid = 1'b0;
        last_mem = 32'd0;
        last_if = 32'd0;
        tick;
        do_load(32'h300, 3'd4, 1'b0);
        do_fetch(32'h0);

        // Address wrap past the top of the byte address space.
        do_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'd4);
        do_load(32'hFFFF_FFFE, 3'd4, 1'b0);
        do_load(32'hFFFF_FFFF, 3'd2, 1'b1);

        // Random mix; odd lengths are serviced as word accesses.
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 2));
            ra = $urandom;
            rd = $urandom;
            if (op == 0) do_load(ra, 3'($urandom_range(0, 7)), 1'($urandom));
            else if (op == 1) do_store(ra, rd, 3'($urandom_range(0, 7)));
            else begin
                if ($urandom_range(0, 2) == 0) ra = prev_fetch;
                do_fetch(ra);
                prev_fetch = ra;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the MEM stage.
- Serves 1/2/4-byte loads and stores from the MEM stage, plus 4-byte instruction fetches, over a single byte-wide synchronous RAM port.
- Serialises each access into byte transfers, assembles and sign/zero-extends load data, and arbitrates between data and fetch with data priority.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  MEM-stage load request (level).
- mem_write  in  1  MEM-stage store request (level).
- mem_addr  in  ADDR_WIDTH  data byte address.
- mem_data_i  in  32  store data; little-endian, low bytes used.
- mem_length  in  3  access size in bytes: 1, 2 or 4.
- mem_signed  in  1  load sign-extend enable.
- mem_busy  out  1  controller occupied (any requester).
- mem_ready  out  1  one-cycle pulse: MEM access complete.
- mem_data_o  out  32  extended load data, valid with mem_ready.
- if_read  in  1  instruction fetch request (level), always 4 bytes.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_busy  out  1  equals mem_busy.
- if_ready  out  1  one-cycle pulse: fetch complete.
- if_data_o  out  32  fetched word, valid with if_ready.
- ram_a  out  ADDR_WIDTH  RAM byte address.
- ram_din  in  8  RAM read data; 1-cycle latency after ram_a.
- ram_dout  out  8  RAM write data.
- ram_wr  out  1  RAM write enable (1 = write, 0 = read).

Behaviour:
- Reset values: state IDLE; ram_a 0, ram_dout 0, ram_wr 0; mem_busy, if_busy, mem_ready, if_ready 0; mem_data_o, if_data_o 0; byte counter 0.
- States: IDLE, READ, WRITE.
- IDLE:
  - Sample requests each edge. Priority: mem_write > mem_read > if_read.
  - A requester whose ready is high in the current cycle is ignored for that edge.
  - Accepting edge E0 latches base address, length, signed flag, owner (MEM/IF) and store data, then moves to READ or WRITE.
- Byte transfers: n = length; any length other than 1 or 2 is serviced as 4. Byte k is transferred at address base+k, wrap-around modulo 2^ADDR_WIDTH.
- READ:
  - ram_a = base+k after edge Ek, for k = 0..n-1; ram_wr = 0.
  - ram_din captured into byte lane k-1 at edge Ek, k = 1..n.
  - At edge En: go to IDLE; owner's ready = 1 for exactly one cycle with data.
  - Load latency: n+1 cycles from acceptance to ready.
- WRITE:
  - After edge Ek, k = 0..n-1: ram_a = base+k, ram_dout = store byte k, ram_wr = 1.
  - At edge En: ram_wr = 0, go to IDLE, mem_ready pulse.
- Load extension:
  - Length 1: signed replicates bit 7; unsigned zero-fills.
  - Length 2: signed replicates bit 15; unsigned zero-fills.
  - Length 4: unmodified.
  - if_data_o is never extended.
- Busy: mem_busy = if_busy = (state != IDLE). Low in the ready cycle.
- Hold rule: data outputs hold their last value until the next completion of the same owner.
- Simultaneous mem_read and mem_write: write wins; the read is not serviced.
- Request changes after acceptance are ignored until completion.
- Reset mid-operation: immediate return to reset values, including ram_wr = 0. Bytes already written stay written. No ready pulse is issued.

Optional Feature:
- Macro: MEM_CTRL_IFETCH_BUF_EN.
- Defined:
  - One-entry fetch buffer holds the last fetched word, its address and a valid bit.
  - if_read to a valid matching address when IDLE and no MEM request is present: no RAM access, if_ready at the next edge with the buffered word.
  - Any accepted store clears valid; reset clears valid.
- Undefined: every fetch accesses RAM. Timing is identical to a 4-byte READ.

Test Plan:
- Unsigned byte load: RAM[0x100]=0x80; mem_read, addr 0x100, len 1, signed 0 -> mem_ready 2 cycles after acceptance, mem_data_o 0x00000080.
- Signed halfword load: RAM[0x200..201]=0x34,0xF2; len 2, signed 1 -> ready after 3 cycles, data 0xFFFFF234; ram_a sequence 0x200, 0x201.
- Word store: mem_write, addr 0x10, data 0xDEADBEEF, len 4 -> ram_wr high 4 cycles, bytes EF, BE, AD, DE at 0x10..0x13; mem_ready 1 cycle after last write.
- Arbitration: mem_read and if_read raised the same edge -> MEM served first (busy on both sides); fetch accepted the edge after mem_ready; if_data_o matches RAM.
- Reset mid-store: reset asserted after 2 bytes written -> ram_wr 0 immediately, no ready; bytes 0..1 changed, 2..3 untouched.
- With MEM_CTRL_IFETCH_BUF_EN: fetch 0x0 twice -> second if_ready 1 cycle after request with no ram_a activity; after a store, the next fetch of 0x0 re-reads RAM (5 cycles).
